// File: rtl/fifo_pkg.sv
// Shared definitions for the flow-controlled FIFO: width helpers and the
// error code enum used by downstream status registers.
package fifo_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Occupancy must represent 0..DEPTH inclusive, hence DEPTH+1 states.
  function automatic int cntWidth(input int addrWidth);
    return clog2((1 << addrWidth) + 1);
  endfunction

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OVF  = 2'd1,
    ERR_UNF  = 2'd2
  } errCode_e;

endpackage

// File: rtl/fifo_ram_2p.sv
// Storage array: one write port, one registered read port, no reset.
// Read-first on address collision so a full-FIFO push+pop returns the oldest entry.
module fifo_ram_2p #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/fifo_flow_ctrl.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds,
// hysteresis pause output and sticky overflow/underflow flags.
module fifo_flow_ctrl
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 6,
  parameter  int ADDR_WIDTH = 2,
  localparam int CNT_W      = cntWidth(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  input  logic [CNT_W-1:0]      afull_thr,
  input  logic [CNT_W-1:0]      aempty_thr,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [CNT_W-1:0]      count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  pause,
  output logic                  err_overflow,
  output logic                  err_underflow,
  output logic                  error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  valid_q, pause_q, pause_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  hasData_q;
  logic                  popOk, pushOk;
  logic [DATA_WIDTH-1:0] ramRdata;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign popOk  = pop && !empty;
  assign pushOk = push && (!full || popOk);

  always_comb begin
    count_d = count_q + CNT_W'(pushOk) - CNT_W'(popOk);
    pause_d = pause_q;
    // Set is checked first so misordered thresholds resolve towards pausing.
    if (count_d >= afull_thr)       pause_d = 1'b1;
    else if (count_d <= aempty_thr) pause_d = 1'b0;
    ovf_d = (push && !pushOk) || (ovf_q && !err_clr);
    unf_d = (pop && !popOk) || (unf_q && !err_clr);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      pause_q   <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      hasData_q <= 1'b0;
    end else begin
      if (pushOk) wrPtr_q <= wrPtr_q + 1'b1;
      if (popOk) begin
        rdPtr_q   <= rdPtr_q + 1'b1;
        hasData_q <= 1'b1;
      end
      count_q <= count_d;
      valid_q <= popOk;
      pause_q <= pause_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  fifo_ram_2p #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) uRam (
    .clk_i  (clk),
    .we_i   (pushOk),
    .waddr_i(wrPtr_q),
    .wdata_i(data_in),
    .re_i   (popOk),
    .raddr_i(rdPtr_q),
    .rdata_o(ramRdata)
  );

  // The RAM read register has no reset, so mask it until the first real pop.
  assign data_out      = hasData_q ? ramRdata : '0;
  assign valid_out     = valid_q;
  assign count         = count_q;
  assign almost_empty  = !empty && (count_q <= aempty_thr);
  assign almost_full   = (count_q >= afull_thr);
  assign pause         = pause_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;
  assign error         = ovf_q || unf_q;

endmodule
